// File: rtl/cpu_ctrl_seq_if.sv
// cpu_ctrl_seq_if: fetch-to-sequencer handshake plus datapath control strobes
interface cpu_ctrl_seq_if #(parameter int DATA_W = 19, parameter int PC_W = 19);
  logic instr_valid, instr_ready;
  logic [4:0] op, funct;
  logic [DATA_W-1:0] a, b;
  logic [PC_W-1:0] pc_in;
  logic regwrite, resultsrc, alusrc, memwrite, registersrc;
  logic [1:0] immsrc, pc_sel;
  logic [4:0] alucontrol;
  logic [PC_W-1:0] ret_addr;
  logic ras_empty, ras_full, fault, retire;
  modport master (
    output instr_valid, op, funct, a, b, pc_in,
    input instr_ready, regwrite, resultsrc, alusrc, memwrite, registersrc,
    input immsrc, pc_sel, alucontrol, ret_addr, ras_empty, ras_full, fault, retire
  );
  modport slave (
    input instr_valid, op, funct, a, b, pc_in,
    output instr_ready, regwrite, resultsrc, alusrc, memwrite, registersrc,
    output immsrc, pc_sel, alucontrol, ret_addr, ras_empty, ras_full, fault, retire
  );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with return-address stack; CTRL_RAS_WRAP_EN makes the stack circular
module cpu_ctrl_seq #(
  parameter int DATA_W = 19,
  parameter int PC_W = 19,
  parameter int RAS_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  cpu_ctrl_seq_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
`ifdef CTRL_RAS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;
  state_t state_q, state_d;
  logic [4:0] op_q, op_d, alu_q, alu_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic ready_q, ready_d, rw_q, rw_d, rs_q, rs_d, as_q, as_d, mw_q, mw_d, rgs_q, rgs_d;
  logic retire_q, retire_d, fault_q, fault_d;
  logic [1:0] imm_q, imm_d, psel_q, psel_d;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [PC_W-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic empty, full, is_call, is_ret, is_ld, is_st, taken;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (PW+1)'(RAS_DEPTH);
  assign is_call = op_q == 5'b01110;
  assign is_ret = op_q == 5'b10001;
  assign is_ld = op_q == 5'b01111;
  assign is_st = op_q == 5'b10000;
  assign taken = op_q == 5'b01011 || is_call || (op_q == 5'b01100 && a_q == b_q) || (op_q == 5'b01101 && a_q != b_q);
  // next state, latched instruction, stack update and the strobes the next state will present
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    pc_d = pc_q;
    ready_d = 1'b0;
    rw_d = 1'b0;
    rs_d = 1'b0;
    as_d = 1'b0;
    mw_d = 1'b0;
    rgs_d = 1'b0;
    retire_d = 1'b0;
    imm_d = 2'b00;
    psel_d = 2'b00;
    alu_d = 5'b0;
    fault_d = fault_q;
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    case (state_q)
      FETCH: begin
        ready_d = !(bus.instr_valid && ready_q);
        if (bus.instr_valid && ready_q) begin
          state_d = DECODE;
          op_d = bus.op;
          a_d = bus.a;
          b_d = bus.b;
          pc_d = bus.pc_in;
        end
      end
      DECODE: begin
        if (!WRAP && ((is_call && full) || (is_ret && empty))) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          state_d = EXEC;
          alu_d = op_q;
          imm_d = is_ld ? 2'b01 : is_st ? 2'b10 : (op_q >= 5'd11 && op_q <= 5'd14) ? 2'b11 : 2'b00;
          as_d = is_ld || is_st;
          rw_d = op_q >= 5'd1 && op_q <= 5'd10;
          psel_d = taken ? 2'b01 : is_ret ? 2'b11 : 2'b00;
          retire_d = !(is_ld || is_st);
        end
      end
      EXEC: begin
        if (is_call) begin
          ras_d[ptr_q] = pc_q + PC_W'(1);
          ptr_d = ptr_q + PW'(1);
          cnt_d = full ? cnt_q : cnt_q + (PW+1)'(1);
        end
        if (is_ret && !empty) begin
          ptr_d = ptr_q - PW'(1);
          cnt_d = cnt_q - (PW+1)'(1);
        end
        state_d = (is_ld || is_st) ? MEM : FETCH;
        ready_d = !(is_ld || is_st);
        mw_d = is_st;
        rgs_d = is_st;
        rs_d = is_st;
        as_d = is_ld || is_st;
        retire_d = is_st;
      end
      MEM: begin
        state_d = is_ld ? WB : FETCH;
        ready_d = !is_ld;
        rw_d = is_ld;
        rs_d = is_ld;
        retire_d = is_ld;
      end
      WB: begin
        state_d = FETCH;
        ready_d = 1'b1;
      end
      default: state_d = FAULT;
    endcase
  end
  // sequencer state, registered outputs and stack storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      pc_q <= '0;
      ready_q <= 1'b1;
      rw_q <= 1'b0;
      rs_q <= 1'b0;
      as_q <= 1'b0;
      mw_q <= 1'b0;
      rgs_q <= 1'b0;
      retire_q <= 1'b0;
      imm_q <= '0;
      psel_q <= '0;
      alu_q <= '0;
      fault_q <= 1'b0;
      ras_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      pc_q <= pc_d;
      ready_q <= ready_d;
      rw_q <= rw_d;
      rs_q <= rs_d;
      as_q <= as_d;
      mw_q <= mw_d;
      rgs_q <= rgs_d;
      retire_q <= retire_d;
      imm_q <= imm_d;
      psel_q <= psel_d;
      alu_q <= alu_d;
      fault_q <= fault_d;
      ras_q <= ras_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.instr_ready = ready_q;
  assign bus.regwrite = rw_q;
  assign bus.resultsrc = rs_q;
  assign bus.alusrc = as_q;
  assign bus.memwrite = mw_q;
  assign bus.registersrc = rgs_q;
  assign bus.immsrc = imm_q;
  assign bus.pc_sel = psel_q;
  assign bus.alucontrol = alu_q;
  assign bus.retire = retire_q;
  assign bus.fault = fault_q;
  assign bus.ras_empty = empty;
  assign bus.ras_full = full;
  assign bus.ret_addr = empty ? '0 : ras_q[ptr_q - PW'(1)];
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: directed scoreboard bench for cpu_ctrl_seq; honours CTRL_RAS_WRAP_EN
module tb_cpu_ctrl_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cpu_ctrl_seq_if bus ();
  cpu_ctrl_seq dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [4:0] str;
    logic [1:0] imm;
    logic [4:0] alu;
    logic [1:0] psel;
    logic [18:0] ra;
    int lat;
    int hs;
  } exp_t;
  localparam logic [4:0] RW = 5'b10000, RS = 5'b01000, AS = 5'b00100, MW = 5'b00010, RG = 5'b00001;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  function automatic exp_t mk(logic [4:0] s, logic [1:0] imm, logic [4:0] alu, logic [1:0] ps, logic [18:0] ra, int lat);
    mk.str = s;
    mk.imm = imm;
    mk.alu = alu;
    mk.psel = ps;
    mk.ra = ra;
    mk.lat = lat;
    mk.hs = 0;
  endfunction
  // monitor: every retire pulse is matched against the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.retire) begin
      if (q.size() == 0) chk("unexpected_retire", 1, 0);
      else begin
        e = q.pop_front();
        chk("retire_outputs",
            {bus.regwrite, bus.resultsrc, bus.alusrc, bus.memwrite, bus.registersrc, bus.immsrc, bus.alucontrol, bus.pc_sel, bus.ret_addr},
            {e.str, e.imm, e.alu, e.psel, e.ra});
        chk("retire_latency", cyc - e.hs, e.lat);
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) chk("ready_timeout", 0, 1);
  endtask
  task automatic issue(logic [4:0] op, logic [18:0] a, logic [18:0] b, logic [18:0] pc, exp_t e, bit exp_on = 1'b1);
    wait_ready();
    bus.instr_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.pc_in = pc;
    e.hs = cyc + 1;
    if (exp_on) q.push_back(e);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask
  task automatic idle_check(string name, logic ready, logic empty, logic full, logic flt);
    chk(name, {bus.instr_ready, bus.ras_empty, bus.ras_full, bus.fault, bus.regwrite, bus.resultsrc, bus.alusrc,
               bus.memwrite, bus.registersrc, bus.immsrc, bus.alucontrol, bus.pc_sel, bus.retire},
        {ready, empty, full, flt, 5'b0, 2'b0, 5'b0, 2'b0, 1'b0});
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n;
    bus.instr_valid = 1'b0;
    bus.op = '0;
    bus.funct = '0;
    bus.a = '0;
    bus.b = '0;
    bus.pc_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_check("reset_state", 1, 1, 0, 0);
    chk("reset_ret_addr", bus.ret_addr, 0);
    rst = 1'b0;
    issue(5'b00001, 19'h1, 19'h2, 19'h10, mk(RW, 2'b00, 5'b00001, 2'b00, 0, 1));
    issue(5'b01010, 19'h1, 19'h2, 19'h11, mk(RW, 2'b00, 5'b01010, 2'b00, 0, 1));
    issue(5'b01100, 19'h1234, 19'h1234, 19'h12, mk(0, 2'b11, 5'b01100, 2'b01, 0, 1));
    issue(5'b01100, 19'h1234, 19'h1235, 19'h13, mk(0, 2'b11, 5'b01100, 2'b00, 0, 1));
    issue(5'b01101, 19'h1234, 19'h1234, 19'h14, mk(0, 2'b11, 5'b01101, 2'b00, 0, 1));
    issue(5'b01101, 19'h1234, 19'h1235, 19'h15, mk(0, 2'b11, 5'b01101, 2'b01, 0, 1));
    issue(5'b01011, 19'h0, 19'h0, 19'h16, mk(0, 2'b11, 5'b01011, 2'b01, 0, 1));
    issue(5'b01111, 19'h0, 19'h0, 19'h17, mk(RW | RS, 2'b00, 5'b0, 2'b00, 0, 3));
    issue(5'b10000, 19'h0, 19'h0, 19'h18, mk(RS | AS | MW | RG, 2'b00, 5'b0, 2'b00, 0, 2));
    issue(5'b10010, 19'h0, 19'h0, 19'h19, mk(0, 2'b00, 5'b10010, 2'b00, 0, 1));
    issue(5'b00000, 19'h0, 19'h0, 19'h1A, mk(0, 2'b00, 5'b00000, 2'b00, 0, 1));
    issue(5'b01110, 19'h0, 19'h0, 19'h7FFFF, mk(0, 2'b11, 5'b01110, 2'b01, 0, 1));
    wait_ready();
    chk("call_wrap_pc", {bus.ras_empty, bus.ret_addr}, {1'b0, 19'h0});
    issue(5'b10001, 19'h0, 19'h0, 19'h20, mk(0, 2'b00, 5'b10001, 2'b11, 0, 1));
    wait_ready();
    chk("ras_empty_after_ret", bus.ras_empty, 1);
    for (int i = 0; i < 8; i++)
      issue(5'b01110, 0, 0, 19'h100 + 19'(i), mk(0, 2'b11, 5'b01110, 2'b01, (i == 0) ? 19'h0 : 19'h100 + 19'(i), 1));
    wait_ready();
    chk("ras_full", {bus.ras_full, bus.ras_empty, bus.ret_addr}, {1'b1, 1'b0, 19'h108});
    for (int j = 7; j >= 0; j--)
      issue(5'b10001, 0, 0, 19'h40, mk(0, 2'b00, 5'b10001, 2'b11, 19'h101 + 19'(j), 1));
    wait_ready();
    chk("ras_empty_after_lifo", {bus.ras_full, bus.ras_empty}, 2'b01);
    for (int i = 0; i < 8; i++)
      issue(5'b01110, 0, 0, 19'h200 + 19'(i), mk(0, 2'b11, 5'b01110, 2'b01, (i == 0) ? 19'h0 : 19'h200 + 19'(i), 1));
`ifdef CTRL_RAS_WRAP_EN
    issue(5'b01110, 0, 0, 19'h300, mk(0, 2'b11, 5'b01110, 2'b01, 19'h208, 1));
    wait_ready();
    chk("wrap_full_no_fault", {bus.fault, bus.ras_full, bus.ret_addr}, {1'b0, 1'b1, 19'h301});
    issue(5'b10001, 0, 0, 19'h40, mk(0, 2'b00, 5'b10001, 2'b11, 19'h301, 1));
    for (int j = 7; j >= 1; j--)
      issue(5'b10001, 0, 0, 19'h40, mk(0, 2'b00, 5'b10001, 2'b11, 19'h201 + 19'(j), 1));
    issue(5'b10001, 0, 0, 19'h40, mk(0, 2'b00, 5'b10001, 2'b11, 19'h0, 1));
    wait_ready();
    chk("wrap_underflow", {bus.fault, bus.ras_empty}, 2'b01);
`else
    issue(5'b01110, 0, 0, 19'h300, mk(0, 0, 0, 0, 0, 0), 1'b0);
    repeat (6) @(negedge clk);
    idle_check("overflow_fault", 0, 0, 1, 1);
    bus.instr_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("fault_sticky", {bus.fault, bus.instr_ready}, 2'b10);
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_check("fault_cleared_by_reset", 1, 1, 0, 0);
    rst = 1'b0;
    issue(5'b10001, 0, 0, 19'h50, mk(0, 0, 0, 0, 0, 0), 1'b0);
    repeat (6) @(negedge clk);
    idle_check("underflow_fault", 0, 1, 0, 1);
`endif
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
